// File: rtl/mem_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_master_pkg
//
// Shared definitions for the data-memory initiator (mem_master).
//
// The guarded `define block carries the shared memory-bus macros:
//   `DATA_WIDTH, `MEM_OP_BITS, `MEM_OP_NOP, `MEM_OP_READ, `MEM_OP_WRITE,
//   `DMEMORY_SIZE, and the FSM state encodings `MM_IDLE, `MM_ACCESS, `MM_RESP.
// The package re-exports them as typed localparams so RTL and benches do not
// depend on macro visibility across compilation units.
// -----------------------------------------------------------------------------
`ifndef MEM_MASTER_DEFINES
`define MEM_MASTER_DEFINES
`define DATA_WIDTH    32
`define MEM_OP_BITS   2
`define MEM_OP_NOP    2'b00
`define MEM_OP_READ   2'b01
`define MEM_OP_WRITE  2'b10
`define DMEMORY_SIZE  1024
`define MM_IDLE       2'd0
`define MM_ACCESS     2'd1
`define MM_RESP       2'd2
`endif

package mem_master_pkg;

    localparam int DATA_W = `DATA_WIDTH;
    localparam int OP_W   = `MEM_OP_BITS;

    localparam logic [OP_W-1:0] OP_NOP   = `MEM_OP_NOP;
    localparam logic [OP_W-1:0] OP_READ  = `MEM_OP_READ;
    localparam logic [OP_W-1:0] OP_WRITE = `MEM_OP_WRITE;

    // First illegal word address when address checking is enabled.
    localparam logic [DATA_W-1:0] DMEM_SIZE = DATA_W'(`DMEMORY_SIZE);

    // Wait counter width: covers LATENCY-1 for LATENCY up to 15.
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = `MM_IDLE,
        S_ACCESS = `MM_ACCESS,
        S_RESP   = `MM_RESP
    } mm_state_e;

    // True when a word address lies inside the data RAM.
    function automatic logic addr_in_range(input logic [DATA_W-1:0] a);
        return a < DMEM_SIZE;
    endfunction

endpackage

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
//
// Initiator side of the data-memory interface. Accepts one load/store at a
// time from the MEM stage, holds mem_op active on the RAM bus for LATENCY
// cycles, samples read_data on the last of them and returns the result over a
// response channel with backpressure. Sole driver of the RAM's mem_op.
//
// Optional build macro: MEM_MASTER_ADDR_CHECK_EN
//   defined   - requests with req_addr >= `DMEMORY_SIZE skip the RAM and answer
//               immediately with resp_err=1, resp_rdata=0 (still counted).
//   undefined - resp_err is constant 0, all addresses pass through.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. valid never waits on ready; req_valid is
// ignored while req_ready=0, and resp_rdata/resp_err are held stable while
// resp_valid=1 and resp_ready=0.
//
// Ports:
//   clk, reset        clock (rising edge) and synchronous active-high reset
//   req_valid/ready   request handshake; req_we 1=store 0=load
//   req_addr/wdata    word address and store data
//   resp_valid/ready  response handshake
//   resp_rdata        load data (0 for stores); resp_err address fault
//   address,
//   write_data,
//   mem_op            RAM command bus (NOP outside the access window)
//   read_data         RAM read data, sampled on the last access cycle
//   txn_count         completed response handshakes (wraps)
//   dbg_state_o       current FSM state (mm_state_e encoding)
// -----------------------------------------------------------------------------
module mem_master
    import mem_master_pkg::*;
#(
    parameter int LATENCY   = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DATA_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,
    output logic [DATA_W-1:0]    address,
    output logic [DATA_W-1:0]    write_data,
    output logic [OP_W-1:0]      mem_op,
    input  logic [DATA_W-1:0]    read_data,
    output logic [CNT_WIDTH-1:0] txn_count,
    output logic [1:0]           dbg_state_o
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LATENCY - 1);

    mm_state_e             state_q, state_d;
    logic                  ready_en_q;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_fault;

`ifdef MEM_MASTER_ADDR_CHECK_EN
    assign req_fault = !addr_in_range(req_addr);
`else
    assign req_fault = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register. ready_en_q keeps req_ready low through reset and for the
    // first cycle after it, so the pipeline sees ready one cycle after release.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wait_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        wait_d     = wait_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_op     = OP_NOP;

        unique case (state_q)
            S_IDLE: begin
                req_ready = ready_en_q;
            end

            S_ACCESS: begin
                mem_op = we_q ? OP_WRITE : OP_READ;
                if (wait_q == '0) begin
                    // Last access cycle: capture the RAM word for loads only.
                    rdata_d = we_q ? '0 : read_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            S_RESP: begin
                resp_valid = 1'b1;
                // A new request may only enter as the current response leaves,
                // since there is a single result register.
                req_ready  = ready_en_q & resp_ready;
                if (resp_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Request acceptance is shared by IDLE and RESP; it overrides the
        // RESP->IDLE transition so back-to-back requests skip IDLE.
        if (req_valid && req_ready) begin
            if (req_fault) begin
                // Faulting request: no RAM access, answer on the next cycle.
                state_d = S_RESP;
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                state_d = S_ACCESS;
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                wait_d  = WAIT_INIT;
            end
        end
    end

    assign address     = addr_q;
    assign write_data  = wdata_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign txn_count   = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
//
// Three mem_master instances (LATENCY = 1, 2, 3), each with a small RAM model
// preloaded with 0x1000_0000 + inst*0x100 + word. 'sel' picks the instance
// whose response channel the monitor checks against the expected queue.
// -----------------------------------------------------------------------------
module tb_mem_master;
    import mem_master_pkg::*;

    localparam int N = 3;
    localparam int W = DATA_W + 1;

    logic clk = 1'b0;
    logic reset;

    logic              req_valid  [N];
    logic              req_ready  [N];
    logic              req_we     [N];
    logic [DATA_W-1:0] req_addr   [N];
    logic [DATA_W-1:0] req_wdata  [N];
    logic              resp_valid [N];
    logic              resp_ready [N];
    logic [DATA_W-1:0] resp_rdata [N];
    logic              resp_err   [N];
    logic [DATA_W-1:0] address    [N];
    logic [DATA_W-1:0] write_data [N];
    logic [OP_W-1:0]   mem_op     [N];
    logic [DATA_W-1:0] read_data  [N];
    logic [31:0]       txn_count  [N];
    logic [1:0]        dbg_state  [N];

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int cyc   = 0;
    int hs_cnt = 0;
    int rd_cnt[N];
    int wr_cnt[N];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs + RAM models ----------------
    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [DATA_W-1:0] ram [16];

        initial begin
            for (int k = 0; k < 16; k++) ram[k] = 32'h1000_0000 + 32'(g * 256 + k);
        end

        always @(posedge clk) begin
            if (mem_op[g] == OP_WRITE) ram[address[g][3:0]] <= write_data[g];
        end

        assign read_data[g] = ram[address[g][3:0]];

        mem_master #(.LATENCY(g + 1), .CNT_WIDTH(32)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_we      (req_we[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .resp_valid  (resp_valid[g]),
            .resp_ready  (resp_ready[g]),
            .resp_rdata  (resp_rdata[g]),
            .resp_err    (resp_err[g]),
            .address     (address[g]),
            .write_data  (write_data[g]),
            .mem_op      (mem_op[g]),
            .read_data   (read_data[g]),
            .txn_count   (txn_count[g]),
            .dbg_state_o (dbg_state[g])
        );
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mem_op[i] == OP_READ)  rd_cnt[i]++;
            if (mem_op[i] == OP_WRITE) wr_cnt[i]++;
        end
        if (!reset && resp_valid[sel] === 1'b1 && resp_ready[sel] === 1'b1) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected inst=%0d: got err=%0b rdata=%h, required no response",
                         sel, resp_err[sel], resp_rdata[sel]);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({resp_err[sel], resp_rdata[sel]} !== mon_exp) begin
                    bad++;
                    $display("FAIL resp_data inst=%0d: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             sel, resp_err[sel], resp_rdata[sel], mon_exp[W-1], mon_exp[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic err, input logic [DATA_W-1:0] rdata);
        exp_q.push_back({err, rdata});
    endtask

    // Drive a request and wait for its acceptance edge; req_valid stays high
    // afterwards so the caller can chain requests back-to-back.
    task automatic issue(input int i, input logic we, input logic [DATA_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, output int acc_cyc);
        int n;
        n = 0;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL req_ready_timeout inst=%0d: got ready=%b after %0d cycles, required 1", i, req_ready[i], n);
        end
        tick();
        acc_cyc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc[4];
        int hs0;
        int rd0;
        int vcount;

        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b1;
            req_we[i]     = 1'b0;
            req_addr[i]   = 32'd5;
            req_wdata[i]  = 32'hDEAD_BEEF;
            resp_ready[i] = 1'b1;
            rd_cnt[i]     = 0;
            wr_cnt[i]     = 0;
        end
        reset = 1'b1;

        // Reset held 3 cycles with req_valid asserted.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_mem_op", 64'(mem_op[0]), 64'(OP_NOP));
            check("rst_req_ready", 64'(req_ready[0]), 64'd0);
            check("rst_txn_count", 64'(txn_count[0]), 64'd0);
        end
        check("rst_resp_valid", 64'(resp_valid[0]), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata[0]), 64'd0);
        check("rst_address", 64'(address[0]), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            resp_ready[i] = 1'b0;
        end
        #1;
        check("rel_req_ready_same_cycle", 64'(req_ready[0]), 64'd0);
        tick();
        check("rel_req_ready_next_cycle", 64'(req_ready[0]), 64'd1);
        check("rst_no_ram_access", 64'(rd_cnt[0] + wr_cnt[0]), 64'd0);

        // Store addr 3 / 0xA5, then load addr 3 (LATENCY=1).
        sel = 0;
        resp_ready[0] = 1'b1;
        push_exp(1'b0, 32'h0000_0000);
        issue(0, 1'b1, 32'd3, 32'h0000_00A5, acc[0]);
        push_exp(1'b0, 32'h0000_00A5);
        issue(0, 1'b0, 32'd3, 32'h0, acc[1]);
        req_valid[0] = 1'b0;
        drain();
        check("sl_txn_count", 64'(txn_count[0]), 64'd2);
        check("sl_write_cycles", 64'(wr_cnt[0]), 64'd1);
        check("sl_read_cycles", 64'(rd_cnt[0]), 64'd1);
        check("sl_back_to_idle", 64'(dbg_state[0]), 64'(S_IDLE));

        // Backpressure: resp_ready low for 5 cycles on a load response.
        resp_ready[0] = 1'b0;
        push_exp(1'b0, 32'h0000_00A5);
        issue(0, 1'b0, 32'd3, 32'h0, acc[0]);
        req_valid[0] = 1'b0;
        tick();
        hs0 = hs_cnt;
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", 64'(resp_valid[0]), 64'd1);
            check("bp_resp_rdata", 64'(resp_rdata[0]), 64'h0000_00A5);
            check("bp_state", 64'(dbg_state[0]), 64'(S_RESP));
            check("bp_req_ready", 64'(req_ready[0]), 64'd0);
            check("bp_mem_op", 64'(mem_op[0]), 64'(OP_NOP));
            tick();
        end
        resp_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("bp_handshakes", 64'(hs_cnt - hs0), 64'd1);
        check("bp_txn_count", 64'(txn_count[0]), 64'd3);
        check("bp_read_cycles", 64'(rd_cnt[0]), 64'd2);

        // Back-to-back loads on the LATENCY=2 instance.
        sel = 1;
        resp_ready[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_exp(1'b0, 32'h1000_0100 + 32'(k + 1));
            issue(1, 1'b0, 32'(k + 1), 32'h0, acc[k]);
        end
        req_valid[1] = 1'b0;
        drain();
        for (int k = 1; k < 4; k++) check("b2b_accept_spacing", 64'(acc[k] - acc[k-1]), 64'd3);
        check("b2b_txn_count", 64'(txn_count[1]), 64'd4);
        check("b2b_read_cycles", 64'(rd_cnt[1]), 64'd8);

        // Reset in the 2nd ACCESS cycle of the LATENCY=3 instance.
        sel = 2;
        resp_ready[2] = 1'b1;
        issue(2, 1'b0, 32'd5, 32'h0, acc[0]);
        req_valid[2] = 1'b0;
        check("ra_first_access_op", 64'(mem_op[2]), 64'(OP_READ));
        tick();
        check("ra_second_access_state", 64'(dbg_state[2]), 64'(S_ACCESS));
        reset = 1'b1;
        tick();
        check("ra_mem_op_nop", 64'(mem_op[2]), 64'(OP_NOP));
        check("ra_state_idle", 64'(dbg_state[2]), 64'(S_IDLE));
        check("ra_resp_valid", 64'(resp_valid[2]), 64'd0);
        check("ra_txn_count", 64'(txn_count[2]), 64'd0);
        tick();
        reset = 1'b0;
        vcount = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (resp_valid[2] !== 1'b0) vcount++;
        end
        check("ra_no_response", 64'(vcount), 64'd0);
        check("ra_read_cycles", 64'(rd_cnt[2]), 64'd2);

        // Out-of-range address (`DMEMORY_SIZE) on the LATENCY=1 instance.
        sel = 0;
        resp_ready[0] = 1'b1;
        rd0 = rd_cnt[0];
`ifdef MEM_MASTER_ADDR_CHECK_EN
        push_exp(1'b1, 32'h0);
        issue(0, 1'b0, DMEM_SIZE, 32'h0, acc[0]);
        req_valid[0] = 1'b0;
        check("ac_resp_valid", 64'(resp_valid[0]), 64'd1);
        check("ac_resp_err", 64'(resp_err[0]), 64'd1);
        check("ac_resp_rdata", 64'(resp_rdata[0]), 64'd0);
        check("ac_mem_op", 64'(mem_op[0]), 64'(OP_NOP));
        drain();
        check("ac_no_read", 64'(rd_cnt[0] - rd0), 64'd0);
`else
        push_exp(1'b0, 32'h1000_0000);
        issue(0, 1'b0, DMEM_SIZE, 32'h0, acc[0]);
        req_valid[0] = 1'b0;
        check("pt_mem_op", 64'(mem_op[0]), 64'(OP_READ));
        check("pt_address", 64'(address[0]), 64'(DMEM_SIZE));
        drain();
        check("pt_read_cycles", 64'(rd_cnt[0] - rd0), 64'd1);
        check("pt_resp_err", 64'(resp_err[0]), 64'd0);
`endif
        check("oob_txn_count", 64'(txn_count[0]), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the pipeline (valid/ready).
- Drives the address / write_data / mem_op bus into the data RAM and samples read_data after a fixed access latency.
- Returns the result to the pipeline over a valid/ready response channel with backpressure.
- Sits between the MEM stage and the data RAM; it is the sole driver of the RAM's mem_op.

Parameters:
- LATENCY, 1, RAM access cycles with mem_op held active before read_data is sampled (legal range 1..15).
- CNT_WIDTH, 32, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  pipeline request valid.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  `DATA_WIDTH  word address.
- req_wdata  input  `DATA_WIDTH  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  pipeline accepts response.
- resp_rdata  output  `DATA_WIDTH  load data (0 for stores).
- resp_err  output  1  address fault (ADDR_CHECK_EN only, else 0).
- address  output  `DATA_WIDTH  to RAM.
- write_data  output  `DATA_WIDTH  to RAM.
- mem_op  output  `MEM_OP_BITS  to RAM: `MEM_OP_READ / `MEM_OP_WRITE / `MEM_OP_NOP.
- read_data  input  `DATA_WIDTH  from RAM.
- txn_count  output  CNT_WIDTH  completed response handshakes.

Behaviour:
- Reset: all of the following are 0 — state, req_ready, resp_valid, resp_rdata, resp_err, address, write_data, txn_count, wait counter. mem_op = `MEM_OP_NOP. Reset wins over any in-flight transaction: the access is abandoned and no response is produced. req_ready rises 1 cycle after reset deasserts.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata and go to ACCESS; counter = LATENCY-1.
  - ACCESS: mem_op = READ or WRITE from the latched request; address and write_data registered and stable for all LATENCY cycles. Counter decrements each cycle. In the cycle where counter==0, read_data is registered into resp_rdata (loads only; stores load 0), then go to RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err stable until the handshake. On resp_ready, txn_count increments (wraps at 2^CNT_WIDTH).
- Leaving RESP:
  - resp_ready with a new req_valid: go directly to ACCESS (req_ready = resp_ready while in RESP).
  - resp_ready without req_valid: go to IDLE.
  - no resp_ready: hold in RESP.
- mem_op is `MEM_OP_NOP in every state except ACCESS; address and write_data keep their last values.
- Latency, LATENCY=1: request accepted at edge N, mem_op active in cycle N+1, resp_valid from cycle N+2. Peak throughput is one transaction per LATENCY+1 cycles with resp_ready tied high.
- req_valid is ignored whenever req_ready=0; there is no internal queue.

Optional Feature:
- MEM_MASTER_ADDR_CHECK_EN
- Defined: a request with req_addr >= `DMEMORY_SIZE issues no RAM access (mem_op stays NOP) and goes IDLE->RESP with resp_err=1 and resp_rdata=0. The response is still counted in txn_count.
- Undefined: resp_err is tied 0 and every address is passed through unchanged.

Decomposition:
- Shared defines.vh holds `DATA_WIDTH, `MEM_OP_BITS, `MEM_OP_READ, `MEM_OP_WRITE, `DMEMORY_SIZE, plus new `MEM_OP_NOP and the FSM state encodings (`MM_IDLE, `MM_ACCESS, `MM_RESP).
- No sub-module: the FSM, latency counter and transaction counter stay in one module.

Test Plan:
- Reset held 3 cycles with req_valid=1: no RAM access, mem_op=NOP, req_ready=0, txn_count=0. After release, req_ready=1 on the next cycle.
- Store addr 3 / data 0x0000_00A5, then load addr 3, resp_ready=1, LATENCY=1: store response has resp_rdata=0; load resp_rdata=0x0000_00A5; RAM sees exactly 1 WRITE cycle and 1 READ cycle; txn_count=2.
- resp_ready held 0 for 5 cycles during a load response: resp_valid, resp_rdata and state held, req_ready=0, mem_op=NOP. Release -> one handshake only.
- Back-to-back loads with req_valid and resp_ready high, LATENCY=2: RESP->ACCESS with no IDLE cycle; one response every 3 cycles.
- LATENCY=3, reset asserted in the 2nd ACCESS cycle: mem_op=NOP next cycle, no resp_valid, txn_count unchanged.
- With MEM_MASTER_ADDR_CHECK_EN, load addr `DMEMORY_SIZE: mem_op never leaves NOP; resp_err=1, resp_rdata=0 one cycle after acceptance.
